// File: rtl/dtw_cost_history_pkg.sv
// Shared constants and helpers for the DTW cost-history buffer and its lane muxes.
// Default geometry matches the fixed 6-lane, 2-deep, 3-port cost cache.
package dtw_cost_history_pkg;

    localparam int DEF_NPE   = 6;
    localparam int DEF_DW    = 16;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_NPORT = 3;

    // Read-port roles in the default DTW mapping
    localparam int PORT_DIAG = 0;
    localparam int PORT_UP   = 1;
    localparam int PORT_LEFT = 2;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dtw_cost_history_lane_mux.sv
// One crossbar output word: picks history[age][sel], or all-ones INF when the
// requested slot is not (yet) valid or the lane select is out of range.
module dtw_lane_mux
    import dtw_cost_history_pkg::*;
#(
    parameter int NPE   = DEF_NPE,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SELW  = clog2(NPE + 1),
    parameter int AGEW  = clog2(DEPTH + 1)
) (
    input  logic [DEPTH*NPE*DW-1:0] hist_i,
    input  logic [AGEW-1:0]         age_i,
    input  logic [SELW-1:0]         sel_i,
    input  logic [AGEW-1:0]         fill_i,
    output logic [DW-1:0]           word_o
);

    logic inRange;

    assign inRange = (age_i != '0) && (int'(age_i) <= DEPTH) &&
                     (age_i <= fill_i) && (int'(sel_i) < NPE);

    // Slot k of hist_i holds age k+1; lane l of a slot sits at offset l*DW
    always_comb begin
        word_o = '1;
        for (int k = 0; k < DEPTH; k++) begin
            for (int l = 0; l < NPE; l++) begin
                if (inRange && (int'(age_i) == k + 1) && (int'(sel_i) == l)) begin
                    word_o = hist_i[(k*NPE + l)*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/dtw_cost_history.sv
// Cost-history buffer for the DTW systolic datapath: keeps the last DEPTH cost
// vectors and serves registered per-port, per-lane neighbour selections.
module dtw_cost_history
    import dtw_cost_history_pkg::*;
#(
    parameter int NPE   = DEF_NPE,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NPORT = DEF_NPORT,
    parameter int SELW  = clog2(NPE + 1),
    parameter int AGEW  = clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       ena,
    input  logic                       i_start,
    input  logic                       i_valid,
    input  logic [NPE*DW-1:0]          i_d,
    input  logic [NPORT*AGEW-1:0]      i_age,
    input  logic [NPORT*NPE*SELW-1:0]  i_sel,
    output logic [NPORT*NPE*DW-1:0]    o_d,
    output logic                       o_valid,
    output logic [AGEW-1:0]            o_fill
);

    localparam int VW = NPE * DW;
    localparam int HW = DEPTH * VW;

    logic [HW-1:0]          histQ, histD;
    logic [AGEW-1:0]        fillQ, fillD;
    logic [NPORT*VW-1:0]    odQ, xbarWord;
    logic                   validQ;
    logic [VW-1:0]          vecIn;

    // Internal slots keep lane 0 at the LSBs, the reverse of the port ordering
    always_comb begin
        vecIn = '0;
        for (int l = 0; l < NPE; l++) begin
            vecIn[l*DW +: DW] = i_d[(NPE-1-l)*DW +: DW];
        end
    end

    always_comb begin
        histD = histQ;
        fillD = fillQ;
        if (i_valid && i_start) begin
            histD          = '1;
            histD[VW-1:0]  = vecIn;
            fillD          = AGEW'(1);
        end else if (i_valid) begin
            histD          = histQ << VW;
            histD[VW-1:0]  = vecIn;
            if (int'(fillQ) < DEPTH) begin
                fillD = fillQ + AGEW'(1);
            end
        end else if (i_start) begin
            histD = '1;
            fillD = '0;
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        for (genvar l = 0; l < NPE; l++) begin : g_lane
            localparam int POS = NPORT*NPE - 1 - (p*NPE + l);

            dtw_lane_mux #(
                .NPE   (NPE),
                .DW    (DW),
                .DEPTH (DEPTH),
                .SELW  (SELW),
                .AGEW  (AGEW)
            ) u_mux (
                .hist_i (histQ),
                .age_i  (i_age[(NPORT-1-p)*AGEW +: AGEW]),
                .sel_i  (i_sel[POS*SELW +: SELW]),
                .fill_i (fillQ),
                .word_o (xbarWord[POS*DW +: DW])
            );
        end
    end

    // The crossbar reads pre-update history, so same-cycle i_d never bypasses
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            histQ  <= '1;
            fillQ  <= '0;
            odQ    <= '1;
            validQ <= 1'b0;
        end else if (ena) begin
            histQ  <= histD;
            fillQ  <= fillD;
            odQ    <= xbarWord;
            validQ <= i_valid;
        end
    end

    assign o_d     = odQ;
    assign o_valid = validQ;
    assign o_fill  = fillQ;

endmodule

// File: tb/tb_dtw_cost_history.sv
// Directed bench for dtw_cost_history: default geometry plus an 8-lane,
// 24-bit, 4-deep, 2-port instance, with hand-computed expected words.
module tb_dtw_cost_history;
    import dtw_cost_history_pkg::*;

    localparam int A_NPE = 6, A_DW = 16, A_DEPTH = 2, A_NPORT = 3, A_SELW = 3, A_AGEW = 2;
    localparam int B_NPE = 8, B_DW = 24, B_DEPTH = 4, B_NPORT = 2, B_SELW = 4, B_AGEW = 3;
    localparam logic [63:0] INF_A = 64'hffff;
    localparam logic [63:0] INF_B = 64'hffffff;

    logic clk;
    logic nrst;

    logic                           enaA, startA, validA;
    logic [A_NPE*A_DW-1:0]          iDA;
    logic [A_NPORT*A_AGEW-1:0]      iAgeA;
    logic [A_NPORT*A_NPE*A_SELW-1:0] iSelA;
    logic [A_NPORT*A_NPE*A_DW-1:0]  oDA;
    logic                           oValidA;
    logic [A_AGEW-1:0]              oFillA;

    logic                           enaB, startB, validB;
    logic [B_NPE*B_DW-1:0]          iDB;
    logic [B_NPORT*B_AGEW-1:0]      iAgeB;
    logic [B_NPORT*B_NPE*B_SELW-1:0] iSelB;
    logic [B_NPORT*B_NPE*B_DW-1:0]  oDB;
    logic                           oValidB;
    logic [B_AGEW-1:0]              oFillB;

    int checkCount;
    int passCount;

    dtw_cost_history dutA (
        .clk     (clk),
        .nrst    (nrst),
        .ena     (enaA),
        .i_start (startA),
        .i_valid (validA),
        .i_d     (iDA),
        .i_age   (iAgeA),
        .i_sel   (iSelA),
        .o_d     (oDA),
        .o_valid (oValidA),
        .o_fill  (oFillA)
    );

    dtw_cost_history #(
        .NPE   (B_NPE),
        .DW    (B_DW),
        .DEPTH (B_DEPTH),
        .NPORT (B_NPORT)
    ) dutB (
        .clk     (clk),
        .nrst    (nrst),
        .ena     (enaB),
        .i_start (startB),
        .i_valid (validB),
        .i_d     (iDB),
        .i_age   (iAgeB),
        .i_sel   (iSelB),
        .o_d     (oDB),
        .o_valid (oValidB),
        .o_fill  (oFillB)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount = checkCount + 1;
        if (got === exp) begin
            passCount = passCount + 1;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic setAgeA(input int p, input int v);
        iAgeA[(A_NPORT-1-p)*A_AGEW +: A_AGEW] = A_AGEW'(v);
    endtask

    task automatic setSelA(input int p, input int l, input int v);
        iSelA[(A_NPORT*A_NPE-1-(p*A_NPE+l))*A_SELW +: A_SELW] = A_SELW'(v);
    endtask

    task automatic setVecA(input int base);
        for (int l = 0; l < A_NPE; l++) iDA[(A_NPE-1-l)*A_DW +: A_DW] = A_DW'(base + l);
    endtask

    // Every lane of every port on dutA selects a lane: identity (rev=0) or 5-l (rev=1)
    task automatic setAllSelA(input bit rev);
        for (int p = 0; p < A_NPORT; p++)
            for (int l = 0; l < A_NPE; l++) setSelA(p, l, rev ? (A_NPE-1-l) : l);
    endtask

    function automatic logic [63:0] wordA(input int p, input int l);
        return 64'(oDA[(A_NPORT*A_NPE-1-(p*A_NPE+l))*A_DW +: A_DW]);
    endfunction

    task automatic setAgeB(input int p, input int v);
        iAgeB[(B_NPORT-1-p)*B_AGEW +: B_AGEW] = B_AGEW'(v);
    endtask

    task automatic setSelB(input int p, input int l, input int v);
        iSelB[(B_NPORT*B_NPE-1-(p*B_NPE+l))*B_SELW +: B_SELW] = B_SELW'(v);
    endtask

    task automatic setVecB(input int base);
        for (int l = 0; l < B_NPE; l++) iDB[(B_NPE-1-l)*B_DW +: B_DW] = B_DW'(base + l);
    endtask

    function automatic logic [63:0] wordB(input int p, input int l);
        return 64'(oDB[(B_NPORT*B_NPE-1-(p*B_NPE+l))*B_DW +: B_DW]);
    endfunction

    // Drive the control inputs, then advance one clock and settle 1 unit past the edge
    task automatic applyStimulus(input logic vA, input logic sA, input logic eA, input logic vB);
        validA = vA;
        startA = sA;
        enaA   = eA;
        validB = vB;
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence
    initial begin
        checkCount = 0;
        passCount  = 0;
        nrst   = 1'b0;
        enaA   = 1'b1; startA = 1'b0; validA = 1'b0;
        enaB   = 1'b1; startB = 1'b0; validB = 1'b0;
        iDA    = '0;   iAgeA  = '0;   iSelA  = '0;
        iDB    = '0;   iAgeB  = '0;   iSelB  = '0;

        #12;
        $display("[TB] reset state");
        checkOutput("rst_valid", 64'(oValidA), 64'd0);
        checkOutput("rst_fill", 64'(oFillA), 64'd0);
        checkOutput("rst_d00", wordA(PORT_DIAG, 0), INF_A);
        checkOutput("rst_d25", wordA(PORT_LEFT, 5), INF_A);
        checkOutput("rst_fillB", 64'(oFillB), 64'd0);
        nrst = 1'b1;
        @(negedge clk);

        $display("[TB] empty history reads INF");
        for (int p = 0; p < A_NPORT; p++) setAgeA(p, 1);
        setAllSelA(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("empty_d10", wordA(PORT_UP, 0), INF_A);
        checkOutput("empty_valid", 64'(oValidA), 64'd0);

        $display("[TB] first vector 1..6");
        setVecA(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_valid", 64'(oValidA), 64'd1);
        checkOutput("t1_fill", 64'(oFillA), 64'd1);
        checkOutput("t1_nobypass", wordA(PORT_UP, 0), INF_A);
        setAgeA(PORT_DIAG, 2);
        setSelA(PORT_LEFT, 4, 6);
        setSelA(PORT_LEFT, 5, 7);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_up0", wordA(PORT_UP, 0), 64'd1);
        checkOutput("t1_up5", wordA(PORT_UP, 5), 64'd6);
        checkOutput("t1_left0", wordA(PORT_LEFT, 0), 64'd1);
        checkOutput("t1_sel6", wordA(PORT_LEFT, 4), INF_A);
        checkOutput("t1_sel7", wordA(PORT_LEFT, 5), INF_A);
        checkOutput("t1_agefill", wordA(PORT_DIAG, 0), INF_A);
        checkOutput("t1_valid0", 64'(oValidA), 64'd0);

        $display("[TB] A then B, reversed lanes");
        setVecA(10);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        setVecA(20);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        setAgeA(PORT_DIAG, 2);
        setAgeA(PORT_UP, 1);
        setAgeA(PORT_LEFT, 3);
        setAllSelA(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_diag0", wordA(PORT_DIAG, 0), 64'd15);
        checkOutput("t2_diag5", wordA(PORT_DIAG, 5), 64'd10);
        checkOutput("t2_up0", wordA(PORT_UP, 0), 64'd25);
        checkOutput("t2_up5", wordA(PORT_UP, 5), 64'd20);
        checkOutput("t2_age3", wordA(PORT_LEFT, 2), INF_A);
        checkOutput("t2_fill", 64'(oFillA), 64'd2);
        setVecA(40);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_fillsat", 64'(oFillA), 64'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_shift_diag0", wordA(PORT_DIAG, 0), 64'd25);
        checkOutput("t2_shift_up0", wordA(PORT_UP, 0), 64'd45);

        $display("[TB] start with valid");
        setAgeA(PORT_DIAG, 1);
        setAgeA(PORT_UP, 2);
        setAgeA(PORT_LEFT, 1);
        setAllSelA(1'b0);
        setVecA(30);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_old_diag0", wordA(PORT_DIAG, 0), 64'd40);
        checkOutput("t4_old_up0", wordA(PORT_UP, 0), 64'd20);
        checkOutput("t4_old_up5", wordA(PORT_UP, 5), 64'd25);
        checkOutput("t4_fill", 64'(oFillA), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_new_diag0", wordA(PORT_DIAG, 0), 64'd30);
        checkOutput("t4_new_diag5", wordA(PORT_DIAG, 5), 64'd35);
        checkOutput("t4_cleared_up0", wordA(PORT_UP, 0), INF_A);

        $display("[TB] enable low holds everything");
        for (int i = 0; i < 3; i++) begin
            setVecA(70 + 8*i);
            setAgeA(PORT_UP, 1);
            setAllSelA(i == 1);
            applyStimulus(i != 1, i == 1, 1'b0, 1'b0);
            checkOutput("hold_diag0", wordA(PORT_DIAG, 0), 64'd30);
            checkOutput("hold_up0", wordA(PORT_UP, 0), INF_A);
            checkOutput("hold_valid", 64'(oValidA), 64'd0);
            checkOutput("hold_fill", 64'(oFillA), 64'd1);
        end
        setAgeA(PORT_UP, 2);
        setAllSelA(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("hold_hist_diag3", wordA(PORT_DIAG, 3), 64'd33);
        checkOutput("hold_hist_up3", wordA(PORT_UP, 3), INF_A);
        checkOutput("hold_hist_fill", 64'(oFillA), 64'd1);

        $display("[TB] reset mid-run");
        nrst = 1'b0;
        #2;
        checkOutput("midrst_fill", 64'(oFillA), 64'd0);
        checkOutput("midrst_valid", 64'(oValidA), 64'd0);
        checkOutput("midrst_diag0", wordA(PORT_DIAG, 0), INF_A);
        nrst = 1'b1;
        #1;
        setVecA(60);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("postrst_diag2", wordA(PORT_DIAG, 2), 64'd62);
        checkOutput("postrst_up2", wordA(PORT_UP, 2), INF_A);
        checkOutput("postrst_fill", 64'(oFillA), 64'd1);

        $display("[TB] wide instance, five pushes");
        for (int k = 1; k <= 5; k++) begin
            setVecB(16*k);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        end
        checkOutput("b_fillsat", 64'(oFillB), 64'd4);
        setAgeB(0, 4);
        setAgeB(1, 0);
        for (int l = 0; l < B_NPE; l++) begin
            setSelB(0, l, l);
            setSelB(1, l, l);
        end
        setSelB(0, 7, 8);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("b_age4_l0", wordB(0, 0), 64'd32);
        checkOutput("b_age4_l6", wordB(0, 6), 64'd38);
        checkOutput("b_sel8", wordB(0, 7), INF_B);
        checkOutput("b_age0", wordB(1, 0), INF_B);
        checkOutput("b_fillhold", 64'(oFillB), 64'd4);
        setAgeB(0, 1);
        setAgeB(1, 5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("b_age1_l3", wordB(0, 3), 64'd83);
        checkOutput("b_age5", wordB(1, 3), INF_B);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
